// File: rtl/rom_arb_pkg.sv
// Shared types and the address legality check used by both ROM ports.
package rom_arb_pkg;

   // Which port owns the ROM in the current cycle.
   typedef enum logic {OWNER_IF, OWNER_LD} owner_t;

   // A legal access is word aligned and indexes a word inside the ROM.
   // Callers zero-extend their address to 64 bits so one function serves any WIDTH up to 64.
   function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
   endfunction

endpackage

// File: rtl/rom_resp_reg.sv
// One-stage response register for a ROM port: rvalid pulses the cycle after a grant,
// rdata carries the ROM word sampled at grant time (zero for an illegal access).
module rom_resp_reg
   import rom_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             gnt,
   input  logic             ok,
   input  logic [WIDTH-1:0] rom_rdata,
   output logic             rvalid,
   output logic [WIDTH-1:0] rdata,
   output logic             err
);

   // Capture the response of this cycle's grant; rdata holds between responses.
   always_ff @(posedge clock) begin
      // NOTE: state is updated with non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= gnt;
         err    <= gnt & ~ok;
         if (gnt) begin
            rdata <= ok ? rom_rdata : '0;
         end
      end
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single-port instruction ROM between the fetch (IF) and load (LD) ports.
// LD has priority but may take at most LD_BURST consecutive grants while IF is waiting.
// Illegal addresses still consume a grant slot but never reach the ROM address bus.
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 2048,
   parameter int LD_BURST = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic             if_gnt,
   output logic             if_rvalid,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_err,
   input  logic             ld_req,
   input  logic [WIDTH-1:0] ld_addr,
   output logic             ld_gnt,
   output logic             ld_rvalid,
   output logic [WIDTH-1:0] ld_rdata,
   output logic             ld_err,
   output logic [WIDTH-1:0] rom_address,
   input  logic [WIDTH-1:0] rom_rdata
);

   localparam int CW = $clog2(LD_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(LD_BURST);

   logic [CW-1:0]    burst_cnt;
   logic [WIDTH-1:0] last_addr;
   owner_t           owner;
   logic             any_gnt;
   logic             gnt_ok;
   logic [WIDTH-1:0] gnt_addr;
   logic             if_ok;
   logic             ld_ok;

   assign if_ok = addr_ok(64'(if_addr), DEPTH);
   assign ld_ok = addr_ok(64'(ld_addr), DEPTH);

   // Grant decision: LD first unless IF is waiting and LD has used up its burst allowance.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      if_gnt = 1'b0;
      ld_gnt = 1'b0;
      owner  = OWNER_IF;
      if (!reset) begin
         if (ld_req && (!if_req || burst_cnt < BURST_MAX)) begin
            ld_gnt = 1'b1;
            owner  = OWNER_LD;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   // Address mux: only a legal granted address is driven; otherwise the last one is held.
   always_comb begin
      any_gnt     = if_gnt | ld_gnt;
      gnt_addr    = (owner == OWNER_LD) ? ld_addr : if_addr;
      gnt_ok      = (owner == OWNER_LD) ? ld_ok : if_ok;
      rom_address = (any_gnt && gnt_ok) ? gnt_addr : last_addr;
   end

   // Burst counter and held ROM address.
   always_ff @(posedge clock) begin
      if (reset) begin
         burst_cnt <= '0;
         last_addr <= '0;
      end else begin
         if (!if_req || if_gnt) begin
            burst_cnt <= '0;
         end else if (ld_gnt && burst_cnt < BURST_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
         if (any_gnt && gnt_ok) begin
            last_addr <= gnt_addr;
         end
      end
   end

   rom_resp_reg #(.WIDTH(WIDTH)) u_if_resp (
      .clock     (clock),
      .reset     (reset),
      .gnt       (if_gnt),
      .ok        (if_ok),
      .rom_rdata (rom_rdata),
      .rvalid    (if_rvalid),
      .rdata     (if_rdata),
      .err       (if_err)
   );

   rom_resp_reg #(.WIDTH(WIDTH)) u_ld_resp (
      .clock     (clock),
      .reset     (reset),
      .gnt       (ld_gnt),
      .ok        (ld_ok),
      .rom_rdata (rom_rdata),
      .rvalid    (ld_rvalid),
      .rdata     (ld_rdata),
      .err       (ld_err)
   );

endmodule
